// File: rtl/filter_biquad_seq.sv
// Time-multiplexed biquad: one shared multiplier/accumulator sequenced over five products per sample.
// Optional build macro FILTER_SAT_EN clamps the output to the signed data range instead of wrapping.
module filter_biquad_seq #(
   parameter int unsigned LARGO = 24,
   parameter int unsigned FRAC  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LARGO:0]   data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [LARGO:0]   data_o,
   output logic             valid_o,
   input  logic             coef_we,
   input  logic [2:0]       coef_sel,
   input  logic [LARGO:0]   coef_data,
   output logic             busy_o
);

   localparam int unsigned W  = LARGO + 1;
   localparam int unsigned PW = 2 * W;
   localparam int unsigned AW = PW + 3;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t state, state_n;
   logic [2:0] step, step_n;
   logic accept_c, mac_en_c, done_en_c;

   logic signed [W-1:0]  x0, x1, x2, y1, y2;
   logic signed [W-1:0]  b0, b1, b2, a1, a2;
   logic signed [AW-1:0] acc;

   logic signed [W-1:0]  coef_c, opnd_c;
   logic signed [PW-1:0] prod_c;
   logic signed [W-1:0]  y_c;

   // State register; ready/busy are registered decodes of the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         step    <= 3'd0;
         ready_o <= 1'b1;
         busy_o  <= 1'b0;
      end else begin
         state   <= state_n;
         step    <= step_n;
         ready_o <= (state_n == IDLE);
         busy_o  <= (state_n != IDLE);
      end
   end

   always_comb begin
      state_n   = state;
      step_n    = step;
      accept_c  = 1'b0;
      mac_en_c  = 1'b0;
      done_en_c = 1'b0;
      case (state)
         IDLE: begin
            if (valid_i) begin
               accept_c = 1'b1;
               state_n  = MAC;
               step_n   = 3'd0;
            end
         end
         MAC: begin
            mac_en_c = 1'b1;
            if (step == 3'd4) begin
               state_n = DONE;
               step_n  = 3'd0;
            end else begin
               step_n = step + 3'd1;
            end
         end
         DONE: begin
            done_en_c = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Operand selection for the current MAC step
   always_comb begin
      coef_c = '0;
      opnd_c = '0;
      case (step)
         3'd0: begin coef_c = b0; opnd_c = x0; end
         3'd1: begin coef_c = b1; opnd_c = x1; end
         3'd2: begin coef_c = b2; opnd_c = x2; end
         3'd3: begin coef_c = a1; opnd_c = y1; end
         3'd4: begin coef_c = a2; opnd_c = y2; end
         default: begin coef_c = '0; opnd_c = '0; end
      endcase
   end

   assign prod_c = PW'(coef_c) * PW'(opnd_c);

`ifdef FILTER_SAT_EN
   localparam logic signed [AW-1:0] YMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [AW-1:0] YMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
   logic signed [AW-1:0] shifted_c;
   assign shifted_c = acc >>> FRAC;
   always_comb begin
      if (shifted_c > YMAX)      y_c = W'(YMAX);
      else if (shifted_c < YMIN) y_c = W'(YMIN);
      else                       y_c = W'(shifted_c);
   end
`else
   assign y_c = W'(acc >>> FRAC);
`endif

   // Datapath: coefficients, accumulator, filter state and output
   always_ff @(posedge clk) begin
      if (rst) begin
         b0      <= W'(1 << FRAC);
         b1      <= '0;
         b2      <= '0;
         a1      <= '0;
         a2      <= '0;
         x0      <= '0;
         x1      <= '0;
         x2      <= '0;
         y1      <= '0;
         y2      <= '0;
         acc     <= '0;
         data_o  <= '0;
         valid_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (state == IDLE && coef_we) begin
            case (coef_sel)
               3'd0: b0 <= coef_data;
               3'd1: b1 <= coef_data;
               3'd2: b2 <= coef_data;
               3'd3: a1 <= coef_data;
               3'd4: a2 <= coef_data;
               default: ;
            endcase
         end
         if (accept_c) begin
            x0  <= data_i;
            acc <= '0;
         end
         // Feedback terms (steps 3 and 4) are subtracted
         if (mac_en_c) begin
            if (step >= 3'd3) acc <= acc - AW'(prod_c);
            else              acc <= acc + AW'(prod_c);
         end
         if (done_en_c) begin
            data_o  <= y_c;
            valid_o <= 1'b1;
            x2      <= x1;
            x1      <= x0;
            y2      <= y1;
            y1      <= y_c;
         end
      end
   end

endmodule
